adder_bist_ctrl: RTL
====================

Name: adder_bist_ctrl

Overview:
- Built-in self-test sequencer for the add_sub_32 datapath. Drives the adder's operand/select inputs and consumes its sum/carry outputs, so it sits at the opposite end of that interface.
- Generates pseudo-random operand pairs from an LFSR and issues an add, then a subtract of the same b. It checks the round trip ((a+b)-b == a) and both carry-out flags.
- Reports pass/fail, a saturating failure count and the first failing vector. Sits beside the ALU; started by the test controller.

Parameters:
- WIDTH, 32, operand/adder width
- NUM_VECTORS, 256, operand pairs per run (1..65535)
- SEED, 32'hACE12468, LFSR seed; 0 is replaced by 32'h00000001

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse when a run completes
- pass  output  1  valid from done until next start; 1 iff fail_count==0
- fail_count  output  16  failing vectors this run, saturates at 16'hFFFF
- fail_a  output  WIDTH  a operand of first failing vector (0 if none)
- fail_b  output  WIDTH  b operand of first failing vector (0 if none)
- add_a  output  WIDTH  to adder a
- add_b  output  WIDTH  to adder b
- add_sel  output  1  to adder sel; 0=add, 1=subtract (a + ~b + 1)
- add_sum  input  WIDTH  from adder sum (combinational path)
- add_cout  input  1  from adder cout; on subtract, 1 = no borrow

Behaviour:
- Reset values: all outputs 0. State=IDLE, LFSR=SEED (or 1), vector counter=0, internal a/b/s/error regs=0.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003). Shifts right; if the old LSB is 1, XOR the mask. Advances only in GEN_A and GEN_B. Operands are the low WIDTH bits of the LFSR state after advancing.
- LFSR is not reseeded between runs, so consecutive runs use fresh vectors. Only rst reloads SEED.
- States:
  - IDLE: on start, clear fail_count/fail_a/fail_b/pass, set busy, go GEN_A.
  - GEN_A: advance LFSR, latch a_reg. Go GEN_B.
  - GEN_B: advance LFSR, latch b_reg. Go ADD.
  - ADD: drive add_a=a_reg, add_b=b_reg, add_sel=0. At the clock edge, capture s_reg=add_sum and err_add = (add_cout != (add_sum < a_reg)). Go SUB.
  - SUB: drive add_a=s_reg, add_b=b_reg, add_sel=1. At the clock edge, capture d_reg=add_sum and err_sub = (add_cout != (s_reg >= b_reg)). Go CHECK.
  - CHECK: vector fails if d_reg != a_reg, or err_add, or err_sub. On fail: fail_count++ (saturating); if this is the first failure, latch fail_a=a_reg and fail_b=b_reg. Increment the vector counter. If counter == NUM_VECTORS, go DONE; else go GEN_A.
  - DONE: pulse done=1, set pass=(fail_count==0), clear busy, go IDLE.
- Latency: 5 cycles per vector. done is asserted on cycle 5*NUM_VECTORS+1 after the start-sampling edge.
- Adder outputs are sampled only at the ADD and SUB edges. In other states, add_a/add_b/add_sel hold their last values (no toggling); after reset they are 0.
- start while busy: ignored. start in the same cycle as DONE: ignored; a new start is accepted the cycle after.
- rst mid-run: returns to IDLE immediately with reset values. No done pulse is generated and results are discarded.
- Comparisons are unsigned at WIDTH bits. Wrap-around is expected and is not itself a failure (e.g. a=FFFFFFFF, b=1 → s=0, add cout=1).

Test Plan:
- Correct adder model, defaults, one start pulse: busy high for 1281 cycles; done pulses on cycle 1281; pass=1; fail_count=0; fail_a=fail_b=0.
- Model ignores sel (always adds): the round trip gives a+2b. fail_count equals the number of vectors with b not in {0, 32'h80000000}, computed by a bench LFSR model. fail_a/fail_b equal the first such pair; pass=0.
- Model with cout stuck at 0: every vector whose add overflows or whose subtract has no borrow fails. fail_count matches the bench reference count; pass=0.
- Override SEED=0 and NUM_VECTORS=1: the first a equals the LFSR advance of 1, which is 32'h80200003. The second advance gives b=32'hC0300002. done is asserted on cycle 6.
- Assert rst at cycle 100 of a run, then start again: no done before the restart. The second run reproduces the same a/b sequence as a fresh run (SEED reloaded).
- Pulse start every cycle during a run, and again in the cycle done is high: exactly one run completes; the second start is accepted only from IDLE afterwards.

Source files
------------

// File: rtl/adder_bist_ctrl.sv
// BIST sequencer for an add/subtract datapath: LFSR operand pairs, add then
// subtract of the same b, round-trip and carry checks, first-failure capture.
module adder_bist_ctrl #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [31:0] SEED        = 32'hACE12468
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      fail_count,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_sel,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_GEN_A, S_GEN_B, S_ADD, S_SUB, S_CHECK, S_DONE
   } state_t;

   localparam logic [31:0] LFSR_MASK = 32'h80200003;
   localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [15:0] NUM_VEC_L = 16'(NUM_VECTORS);

   state_t             state_q;
   logic [31:0]        lfsr_q;
   logic [31:0]        lfsr_d;
   logic [15:0]        cnt_q;
   logic [15:0]        cnt_d;
   logic [WIDTH-1:0]   a_q, b_q, s_q, d_q;
   logic               err_add_q, err_sub_q;
   logic               vec_fail;
   logic               busy_q, done_q, pass_q, add_sel_q;
   logic [15:0]        fail_count_q;
   logic [WIDTH-1:0]   fail_a_q, fail_b_q, add_a_q, add_b_q;

   // Galois step: shift right, fold the mask back in when a 1 falls out.
   assign lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
   assign cnt_d    = cnt_q + 16'd1;
   assign vec_fail = (d_q != a_q) | err_add_q | err_sub_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         lfsr_q       <= SEED_EFF;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         s_q          <= '0;
         d_q          <= '0;
         err_add_q    <= 1'b0;
         err_sub_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_count_q <= '0;
         fail_a_q     <= '0;
         fail_b_q     <= '0;
         add_a_q      <= '0;
         add_b_q      <= '0;
         add_sel_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  fail_count_q <= '0;
                  fail_a_q     <= '0;
                  fail_b_q     <= '0;
                  pass_q       <= 1'b0;
                  busy_q       <= 1'b1;
                  cnt_q        <= '0;
                  state_q      <= S_GEN_A;
               end
            end
            S_GEN_A: begin
               lfsr_q  <= lfsr_d;
               a_q     <= lfsr_d[WIDTH-1:0];
               state_q <= S_GEN_B;
            end
            // Adder inputs are registered, so the add operands go out here
            // to be stable for the whole ADD cycle.
            S_GEN_B: begin
               lfsr_q    <= lfsr_d;
               b_q       <= lfsr_d[WIDTH-1:0];
               add_a_q   <= a_q;
               add_b_q   <= lfsr_d[WIDTH-1:0];
               add_sel_q <= 1'b0;
               state_q   <= S_ADD;
            end
            S_ADD: begin
               s_q       <= add_sum;
               err_add_q <= add_cout != (add_sum < a_q);
               add_a_q   <= add_sum;
               add_sel_q <= 1'b1;
               state_q   <= S_SUB;
            end
            S_SUB: begin
               d_q       <= add_sum;
               err_sub_q <= add_cout != (s_q >= b_q);
               state_q   <= S_CHECK;
            end
            S_CHECK: begin
               if (vec_fail) begin
                  if (fail_count_q != 16'hFFFF) fail_count_q <= fail_count_q + 16'd1;
                  if (fail_count_q == 16'd0) begin
                     fail_a_q <= a_q;
                     fail_b_q <= b_q;
                  end
               end
               cnt_q   <= cnt_d;
               state_q <= (cnt_d == NUM_VEC_L) ? S_DONE : S_GEN_A;
            end
            S_DONE: begin
               done_q  <= 1'b1;
               pass_q  <= (fail_count_q == 16'd0);
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail_count = fail_count_q;
   assign fail_a     = fail_a_q;
   assign fail_b     = fail_b_q;
   assign add_a      = add_a_q;
   assign add_b      = add_b_q;
   assign add_sel    = add_sel_q;
   assign dbg_state  = state_q;

endmodule
